read_respond: RTL and testbench
===============================

READ_RESPOND -- requirements
Module: read_respond

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles a read waits on a busy register before it returns an error response.
REQ-002 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-low.
REQ-004 Port req_valid  input  1  host read request strobe.
REQ-005 Port req_addr  input  5  register index to read.
REQ-006 Port req_ready  output  1  high only in IDLE.
REQ-007 Port resp_valid  output  1  response available.
REQ-008 Port resp_ready  input  1  host accepts response.
REQ-009 Port resp_data  output  32  read data.
REQ-010 Port resp_err  output  1  high when the read timed out.
REQ-011 Port rf_raddr  output  5  register-file read address; the file reads synchronously, so data is valid one cycle later.
REQ-012 Port rf_rdata  input  32  register-file read data.
REQ-013 Port issue_valid  input  1  decoded instruction issued; this is the write-decode write_enable.
REQ-014 Port issue_rd  input  5  destination of the issued instruction.
REQ-015 Port wb_valid  input  1  core writeback strobe.
REQ-016 Port wb_addr  input  5  writeback destination.

Function
REQ-017 The block SHALL hold a 32-bit busy vector.
- issue_valid sets bit issue_rd.
- wb_valid clears bit wb_addr.
- If both strobes target the same bit in the same cycle, the set SHALL win.
REQ-018 FSM states SHALL be IDLE, CHECK, WAIT, FETCH and RESP.
REQ-019 IDLE: on req_valid && req_ready in cycle T, latch req_addr into addr_q and go to CHECK at T+1.
REQ-020 rf_raddr SHALL equal addr_q at all times.
REQ-021 CHECK: if busy[addr_q]==0, go to FETCH; otherwise go to WAIT and clear the wait counter. A busy bit set in cycle T SHALL be seen by CHECK.
REQ-022 WAIT: increment the wait counter each cycle.
- When busy[addr_q]==0, go back to CHECK so the read is relaunched after the writeback has committed.
- When the counter reaches TIMEOUT_CYCLES, go to RESP with data 32'hDEADBEEF and err=1.
REQ-023 FETCH: capture rf_rdata into the response register with err=0, then go to RESP.
REQ-024 RESP: assert resp_valid; resp_data and resp_err SHALL stay stable until resp_valid && resp_ready, then go to IDLE.
REQ-025 Minimum latency SHALL be 3 cycles: handshake at T, resp_valid at T+3.
- With resp_ready held high, the next req_ready SHALL be at T+4.
REQ-026 req_valid outside IDLE SHALL be ignored and SHALL NOT be latched.
REQ-027 The wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide and SHALL saturate, never wrap.
REQ-028 Setting and clearing busy bits SHALL continue in every FSM state.

Reset
REQ-029 While rst is low, the following SHALL be forced:
- state=IDLE, busy=0, addr_q=0, counter=0;
- resp_valid=0, resp_data=0, resp_err=0;
- req_ready SHALL be low while rst is asserted.
REQ-030 A reset asserted mid-transaction SHALL drop any pending response with no output glitch; req_ready SHALL be high in the first cycle after rst is released.

Structure
REQ-031 FSM state encodings, the 32'hDEADBEEF error word and the register-index width SHALL live in core/defs.v.
REQ-032 The busy vector SHALL be the sub-module read_scoreboard.
- Inputs: the set and clear ports.
- Output: busy[31:0].

Verification
REQ-033 Idle register: RF r5=32'h1234_5678, busy=0; request addr 5 at T -> resp_valid at T+3 with data 32'h1234_5678, err=0.
REQ-034 Hazard: issue_rd=7 at T, request addr 7 at T; wb_valid for r7 at T+10 with RF r7=32'hCAFE -> resp_valid no earlier than T+13 with data 32'hCAFE, err=0.
REQ-035 Timeout: TIMEOUT_CYCLES=4, r3 busy and never cleared -> resp_data=32'hDEADBEEF, err=1; req_ready returns after the response is accepted.
REQ-036 Back-pressure and ignore: resp_ready low for 5 cycles -> data stays stable; a second req_valid during this time is ignored and accepted only in IDLE.
REQ-037 Simultaneous events and reset:
- issue and wb to r9 in the same cycle -> busy[9]=1;
- rst pulsed in WAIT -> resp_valid=0 and busy=0 on the next edge.

Source files
------------

// File: rtl/read_respond_pkg.sv
// Shared definitions for the read_respond slice.
//   - REG_IDX_W : register-index width (32 architectural registers)
//   - ERR_WORD  : data word returned when a read times out
//   - state_t   : read FSM state encoding
//   - idx_onehot: one-hot decode of a register index
package read_respond_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WAIT,
    ST_FETCH,
    ST_RESP
  } state_t;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
    idx_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/read_respond_scoreboard.sv
// read_scoreboard: per-register busy vector.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   set_valid/set_idx - mark register set_idx busy (instruction issued)
//   clr_valid/clr_idx - mark register clr_idx free (writeback committed)
//   busy[31:0]        - current busy vector
// A set and a clear of the same bit in one cycle leaves the bit set.
module read_scoreboard
  import read_respond_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_valid,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]  busy
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) set_mask = idx_onehot(set_idx);
    if (clr_valid) clr_mask = idx_onehot(clr_idx);
  end

  // Clear is applied before set so the set wins on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/read_respond.sv
// read_respond: host register-read port guarded by a busy scoreboard.
// A read of a register with an outstanding writeback waits until the
// writeback commits (or TIMEOUT_CYCLES elapse, giving ERR_WORD/err=1).
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   req_valid/req_ready      - read request handshake, req_addr = register
//   resp_valid/resp_ready    - response handshake, resp_data/resp_err
//   rf_raddr/rf_rdata        - synchronous register-file read port
//   issue_valid/issue_rd     - instruction issue, marks destination busy
//   wb_valid/wb_addr         - writeback, marks destination free
module read_respond
  import read_respond_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [REG_IDX_W-1:0] req_addr,
  output logic                 req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [31:0]          rf_rdata,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_addr
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t               state;
  logic [REG_IDX_W-1:0] addr_q;
  logic [CNT_W-1:0]     wait_cnt;
  logic [NUM_REGS-1:0]  busy;

  read_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_idx   (issue_rd),
    .clr_valid (wb_valid),
    .clr_idx   (wb_addr),
    .busy      (busy)
  );

  // Gated by rst so req_ready is low throughout reset and rises in the
  // first cycle after release without waiting for a clock edge.
  assign req_ready = rst && (state == ST_IDLE);
  assign rf_raddr  = addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q <= req_addr;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (busy[addr_q]) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_WAIT: begin
          // Going back through CHECK relaunches the RF read so FETCH sees
          // data written by the committed writeback.
          if (!busy[addr_q]) begin
            state <= ST_CHECK;
          end else if (wait_cnt == CNT_MAX) begin
            resp_data  <= ERR_WORD;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_FETCH: begin
          resp_data  <= rf_rdata;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_respond.sv
module tb_read_respond;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [4:0]  req_addr;
  logic        resp_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  logic        req_ready,   req_ready_4;
  logic        resp_valid,  resp_valid_4;
  logic [31:0] resp_data,   resp_data_4;
  logic        resp_err,    resp_err_4;
  logic [4:0]  rf_raddr,    rf_raddr_4;
  logic [31:0] rf_rdata,    rf_rdata_4;

  logic [31:0] rf [32];
  exp_t        sbq [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_respond dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  read_respond #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_4),
    .resp_valid(resp_valid_4), .resp_ready(resp_ready),
    .resp_data(resp_data_4), .resp_err(resp_err_4),
    .rf_raddr(rf_raddr_4), .rf_rdata(rf_rdata_4),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  // Synchronous register-file model: data one cycle after address.
  always @(posedge clk) begin
    rf_rdata   <= rf[rf_raddr];
    rf_rdata_4 <= rf[rf_raddr_4];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    req_valid = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
    resp_ready = 1'b1;
    tick; tick;
    rst = 1'b1;
    sbq.delete();
  endtask

  task automatic test_reset;
    tick;
    rst = 1'b0;
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (req_ready_4 !== 1'b0) begin errors++; $display("FAIL reset_req_ready_4: got %b want 0", req_ready_4); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    checks++; if (rf_raddr !== 5'd0) begin errors++; $display("FAIL reset_rf_raddr: got %h want 0", rf_raddr); end
    tick;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_idle_read;
    exp_t e;
    rf[5] = 32'h1234_5678;
    tick;
    req_valid = 1'b1; req_addr = 5'd5;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b want 1", req_ready); end
    sbq.push_back('{32'h1234_5678, 1'b0});
    tick;
    req_valid = 1'b0;
    checks++; if (rf_raddr !== 5'd5) begin errors++; $display("FAIL idle_rf_raddr: got %h want 05", rf_raddr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_early_t1: got %b want 0", resp_valid); end
    tick;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_early_t2: got %b want 0", resp_valid); end
    tick;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL idle_latency_t3: got %b want 1", resp_valid); end
    if (resp_valid && resp_ready && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (resp_data !== e.data) begin errors++; $display("FAIL idle_data: got %h want %h", resp_data, e.data); end
      checks++; if (resp_err !== e.err) begin errors++; $display("FAIL idle_err: got %b want %b", resp_err, e.err); end
    end
    tick;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready_t4: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid_drop: got %b want 0", resp_valid); end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [4:0] addrs [3];
    addrs[0] = 5'd0; addrs[1] = 5'd31; addrs[2] = 5'd1;
    for (int i = 0; i < 3; i++) begin
      rf[addrs[i]] = $urandom;
      req_valid = 1'b1; req_addr = addrs[i];
      sbq.push_back('{rf[addrs[i]], 1'b0});
      tick;
      req_valid = 1'b0;
      tick; tick;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_latency[%0d]: got %b want 1", i, resp_valid); end
      if (resp_valid && resp_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++; if (resp_data !== e.data) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, resp_data, e.data); end
        checks++; if (resp_err !== e.err) begin errors++; $display("FAIL b2b_err[%0d]: got %b want %b", i, resp_err, e.err); end
      end
      tick;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
    end
  endtask

  task automatic test_hazard;
    exp_t e;
    int lat;
    bit got;
    do_reset;
    rf[7] = 32'h0;
    got = 1'b0; lat = 0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    req_valid = 1'b1; req_addr = 5'd7;
    sbq.push_back('{32'h0000_CAFE, 1'b0});
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (i == 1) begin issue_valid = 1'b0; req_valid = 1'b0; end
      if (i == 10) begin wb_valid = 1'b1; wb_addr = 5'd7; rf[7] = 32'h0000_CAFE; end
      if (i == 11) wb_valid = 1'b0;
      if (resp_valid) begin got = 1'b1; lat = i; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL hazard_timeout: got no response want response within 40 cycles"); end
    checks++; if (lat < 13) begin errors++; $display("FAIL hazard_latency: got %0d want >= 13", lat); end
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (resp_data !== e.data) begin errors++; $display("FAIL hazard_data: got %h want %h", resp_data, e.data); end
      checks++; if (resp_err !== e.err) begin errors++; $display("FAIL hazard_err: got %b want %b", resp_err, e.err); end
    end
    tick;
  endtask

  task automatic test_timeout;
    exp_t e;
    int lat;
    bit got;
    logic [31:0] held;
    do_reset;
    got = 1'b0; lat = 0;
    resp_ready = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    req_valid = 1'b1; req_addr = 5'd3;
    sbq.push_back('{32'hDEAD_BEEF, 1'b1});
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (i == 1) begin issue_valid = 1'b0; req_valid = 1'b0; end
      if (resp_valid_4) begin got = 1'b1; lat = i; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL timeout_no_resp: got no response want response within 30 cycles"); end
    checks++; if (lat < 6 || lat > 12) begin errors++; $display("FAIL timeout_latency: got %0d want 6..12", lat); end
    checks++; if (req_ready_4 !== 1'b0) begin errors++; $display("FAIL timeout_ready_in_resp: got %b want 0", req_ready_4); end
    held = resp_data_4;
    tick;
    checks++; if (resp_data_4 !== held || resp_valid_4 !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %h/%b want %h/1", resp_data_4, resp_valid_4, held); end
    resp_ready = 1'b1;
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (resp_data_4 !== e.data) begin errors++; $display("FAIL timeout_data: got %h want %h", resp_data_4, e.data); end
      checks++; if (resp_err_4 !== e.err) begin errors++; $display("FAIL timeout_err: got %b want %b", resp_err_4, e.err); end
    end
    tick;
    checks++; if (req_ready_4 !== 1'b1) begin errors++; $display("FAIL timeout_ready_return: got %b want 1", req_ready_4); end
    checks++; if (resp_valid_4 !== 1'b0) begin errors++; $display("FAIL timeout_valid_drop: got %b want 0", resp_valid_4); end
    do_reset;
  endtask

  task automatic test_backpressure;
    exp_t e;
    logic [31:0] held;
    rf[10] = 32'hA5A5_0F0F;
    rf[11] = 32'h5A5A_F0F0;
    resp_ready = 1'b0;
    tick;
    req_valid = 1'b1; req_addr = 5'd10;
    sbq.push_back('{32'hA5A5_0F0F, 1'b0});
    tick;
    req_valid = 1'b0;
    tick; tick;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_latency: got %b want 1", resp_valid); end
    held = resp_data;
    for (int k = 0; k < 5; k++) begin
      checks++; if (resp_valid !== 1'b1 || resp_data !== held || resp_err !== 1'b0) begin
        errors++; $display("FAIL bp_stable[%0d]: got %b/%h/%b want 1/%h/0", k, resp_valid, resp_data, resp_err, held);
      end
      checks++; if (rf_raddr !== 5'd10) begin errors++; $display("FAIL bp_addr_hold[%0d]: got %h want 0a", k, rf_raddr); end
      if (k == 1) begin
        req_valid = 1'b1; req_addr = 5'd11;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_busy: got %b want 0", req_ready); end
      end
      if (k == 2) req_valid = 1'b0;
      tick;
    end
    resp_ready = 1'b1;
    if (resp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (resp_data !== e.data) begin errors++; $display("FAIL bp_data: got %h want %h", resp_data, e.data); end
    end
    tick;
    checks++; if (req_ready !== 1'b1 || rf_raddr !== 5'd10) begin errors++; $display("FAIL bp_ignored_req: got ready %b addr %h want 1/0a", req_ready, rf_raddr); end
    req_valid = 1'b1; req_addr = 5'd11;
    sbq.push_back('{32'h5A5A_F0F0, 1'b0});
    tick;
    req_valid = 1'b0;
    tick; tick;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_second_latency: got %b want 1", resp_valid); end
    if (resp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (resp_data !== e.data) begin errors++; $display("FAIL bp_second_data: got %h want %h", resp_data, e.data); end
    end
    tick;
  endtask

  task automatic test_simultaneous_reset;
    exp_t e;
    do_reset;
    rf[9] = 32'h0909_1234;
    issue_valid = 1'b1; issue_rd = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd9;
    tick;
    issue_valid = 1'b0; wb_valid = 1'b0;
    checks++; if (dut.busy[9] !== 1'b1) begin errors++; $display("FAIL sim_set_wins: got %b want 1", dut.busy[9]); end
    req_valid = 1'b1; req_addr = 5'd9;
    tick;
    req_valid = 1'b0;
    tick; tick; tick;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sim_waiting: got %b want 0", resp_valid); end
    rst = 1'b0;
    #2;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL sim_rst_outputs: got valid %b ready %b want 0/0", resp_valid, req_ready); end
    tick;
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("FAIL sim_rst_busy: got %h want 0", dut.busy); end
    rst = 1'b1;
    sbq.delete();
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sim_rst_release_ready: got %b want 1", req_ready); end
    req_valid = 1'b1; req_addr = 5'd9;
    sbq.push_back('{32'h0909_1234, 1'b0});
    tick;
    req_valid = 1'b0;
    tick; tick;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sim_after_rst_latency: got %b want 1", resp_valid); end
    if (resp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++; if (resp_data !== e.data) begin errors++; $display("FAIL sim_after_rst_data: got %h want %h", resp_data, e.data); end
    end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    resp_ready = 1'b1;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_addr = '0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    test_reset;
    test_idle_read;
    test_back_to_back;
    test_hazard;
    test_timeout;
    test_backpressure;
    test_simultaneous_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
